// File: rtl/fsm1_stim_driver.sv
// Stimulus driver and response checker for the two-input handshake FSM.
// Runs IDLE->S1->S2->IDLE rounds, compares registered responses, recovers on mismatch.
module fsm1_stim_driver #(
    parameter int RW        = 8,
    parameter int GAP       = 0,
    parameter int RECOV_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] rounds,
    input  logic          inject,
    output logic          i1,
    output logic          i2,
    input  logic          o1,
    input  logic          o2,
    input  logic          err,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic          stuck,
    output logic [RW-1:0] rounds_done
);
    typedef enum logic [2:0] {IDLE, STEP, HOLD, TAIL, RECOV} state_e;

    localparam int GW = $clog2(GAP + 2);
    localparam int CW = $clog2(RECOV_MAX + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] REC_LAST = CW'((RECOV_MAX > 0) ? RECOV_MAX - 1 : 0);

    state_e        state_q, state_d;
    logic [1:0]    drv_q, drv_d;
    logic [2:0]    exp_q, exp_d, chk_q, chk_d;
    logic          vld_q, vld_d, last_q, last_d;
    logic          chk_vld_q, chk_vld_d, chk_last_q, chk_last_d;
    logic [1:0]    step_q, step_d;
    logic [RW-1:0] rnd_q, rnd_d, rounds_q, rounds_d, rdone_q, rdone_d;
    logic          inj_q, inj_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          fail_q, fail_d, stuck_q, stuck_d;

    logic [2:0] obs;
    logic       mism, inj_cur, step_last, adv, to_recov, finish;
    logic [5:0] nvec;

    // {drive, expected response, last-step-of-round}
    function automatic logic [5:0] step_vec(input logic [1:0] s, input logic inj);
        logic [5:0] v;
        if (inj) v = (s == 2'd0) ? {2'b10, 3'b111, 1'b0} : {2'b00, 3'b000, 1'b1};
        else begin
            unique case (s)
                2'd0:    v = {2'b11, 3'b100, 1'b0};
                2'd1:    v = {2'b11, 3'b010, 1'b0};
                default: v = {2'b10, 3'b000, 1'b1};
            endcase
        end
        return v;
    endfunction

    // Hold pattern keeps the responder in whatever state the last step produced
    function automatic logic [1:0] hold_drv(input logic [2:0] e);
        logic [1:0] d;
        unique case (e)
            3'b010:  d = 2'b01;
            3'b111:  d = 2'b10;
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    assign obs       = {o1, o2, err};
    assign mism      = chk_vld_q && (obs != chk_q);
    assign inj_cur   = inj_q && (rnd_q == RW'(1));
    assign step_last = inj_cur ? (step_q == 2'd1) : (step_q == 2'd2);

    always_comb begin
        state_d    = state_q;
        drv_d      = drv_q;
        exp_d      = exp_q;
        vld_d      = vld_q;
        last_d     = last_q;
        chk_d      = exp_q;
        chk_vld_d  = vld_q;
        chk_last_d = last_q;
        step_d     = step_q;
        rnd_d      = rnd_q;
        rounds_d   = rounds_q;
        inj_d      = inj_q;
        gcnt_d     = gcnt_q;
        rcnt_d     = rcnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fail_d     = fail_q;
        stuck_d    = stuck_q;
        rdone_d    = rdone_q;
        adv        = 1'b0;
        to_recov   = 1'b0;
        finish     = 1'b0;
        nvec       = '0;

        if (chk_vld_q && !mism && chk_last_q && rdone_q != {RW{1'b1}})
            rdone_d = rdone_q + RW'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rounds_d = rounds;
                    inj_d    = inject;
                    fail_d   = 1'b0;
                    stuck_d  = 1'b0;
                    rdone_d  = '0;
                    if (rounds == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nvec    = step_vec(2'd0, inject);
                        busy_d  = 1'b1;
                        state_d = STEP;
                        step_d  = 2'd0;
                        rnd_d   = RW'(1);
                        drv_d   = nvec[5:4];
                        exp_d   = nvec[3:1];
                        last_d  = nvec[0];
                        vld_d   = 1'b1;
                    end
                end
            end
            STEP: begin
                if (mism) to_recov = 1'b1;
                else if (GAP == 0) adv = 1'b1;
                else begin
                    state_d = HOLD;
                    gcnt_d  = '0;
                    drv_d   = hold_drv(exp_q);
                    last_d  = 1'b0;
                end
            end
            HOLD: begin
                if (mism) to_recov = 1'b1;
                else if (gcnt_q == GAP_LAST) adv = 1'b1;
                else gcnt_d = gcnt_q + GW'(1);
            end
            TAIL: begin
                if (mism) to_recov = 1'b1;
                else finish = 1'b1;
            end
            RECOV: begin
                if (obs == 3'b000) finish = 1'b1;
                else if (rcnt_q == REC_LAST) begin
                    stuck_d = 1'b1;
                    finish  = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + CW'(1);
                    drv_d  = (obs == 3'b100) ? 2'b01 : 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (step_last && rnd_q == rounds_q) begin
                state_d = TAIL;
                drv_d   = 2'b00;
                vld_d   = 1'b0;
                last_d  = 1'b0;
            end else begin
                // Only the first round can carry the injected error
                if (step_last) begin
                    rnd_d  = rnd_q + RW'(1);
                    step_d = 2'd0;
                    nvec   = step_vec(2'd0, 1'b0);
                end else begin
                    step_d = step_q + 2'd1;
                    nvec   = step_vec(step_q + 2'd1, inj_cur);
                end
                state_d = STEP;
                drv_d   = nvec[5:4];
                exp_d   = nvec[3:1];
                last_d  = nvec[0];
                vld_d   = 1'b1;
            end
        end

        if (to_recov) begin
            state_d   = RECOV;
            fail_d    = 1'b1;
            rcnt_d    = '0;
            drv_d     = 2'b00;
            vld_d     = 1'b0;
            last_d    = 1'b0;
            chk_vld_d = 1'b0;
        end

        if (finish) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            drv_d   = 2'b00;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            drv_q      <= 2'b00;
            exp_q      <= 3'b000;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            chk_q      <= 3'b000;
            chk_vld_q  <= 1'b0;
            chk_last_q <= 1'b0;
            step_q     <= 2'd0;
            rnd_q      <= '0;
            rounds_q   <= '0;
            inj_q      <= 1'b0;
            gcnt_q     <= '0;
            rcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            stuck_q    <= 1'b0;
            rdone_q    <= '0;
        end else begin
            state_q    <= state_d;
            drv_q      <= drv_d;
            exp_q      <= exp_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            chk_q      <= chk_d;
            chk_vld_q  <= chk_vld_d;
            chk_last_q <= chk_last_d;
            step_q     <= step_d;
            rnd_q      <= rnd_d;
            rounds_q   <= rounds_d;
            inj_q      <= inj_d;
            gcnt_q     <= gcnt_d;
            rcnt_q     <= rcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            stuck_q    <= stuck_d;
            rdone_q    <= rdone_d;
        end
    end

    assign {i1, i2}    = drv_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign stuck       = stuck_q;
    assign rounds_done = rdone_q;
endmodule

// File: tb/tb_fsm1_stim_driver.sv
// Directed bench for fsm1_stim_driver with behavioural responders.
// Instance a uses GAP=0 (with fault modes), instance b uses GAP=2.
module tb_fsm1_stim_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_start = 0, a_inject = 0, b_start = 0, b_inject = 0;
    logic [7:0] a_rounds = 0, b_rounds = 0;
    logic       a_i1, a_i2, a_o1, a_o2, a_err, a_busy, a_done, a_fail, a_stuck;
    logic       b_i1, b_i2, b_o1, b_o2, b_err, b_busy, b_done, b_fail, b_stuck;
    logic [7:0] a_rd, b_rd;
    int         mode_a = 0;
    logic [1:0] sa, sb;
    int         n_chk = 0, n_err = 0;

    fsm1_stim_driver #(.RW(8), .GAP(0), .RECOV_MAX(8)) dut_a (
        .clk(clk), .rst(rst_n), .start(a_start), .rounds(a_rounds),
        .inject(a_inject), .i1(a_i1), .i2(a_i2), .o1(a_o1), .o2(a_o2),
        .err(a_err), .busy(a_busy), .done(a_done), .fail(a_fail),
        .stuck(a_stuck), .rounds_done(a_rd)
    );

    fsm1_stim_driver #(.RW(8), .GAP(2), .RECOV_MAX(8)) dut_b (
        .clk(clk), .rst(rst_n), .start(b_start), .rounds(b_rounds),
        .inject(b_inject), .i1(b_i1), .i2(b_i2), .o1(b_o1), .o2(b_o2),
        .err(b_err), .busy(b_busy), .done(b_done), .fail(b_fail),
        .stuck(b_stuck), .rounds_done(b_rd)
    );

    // Responder: 0=IDLE 1=S1 2=S2 3=ER
    function automatic logic [1:0] resp_nx(input logic [1:0] s, input logic [1:0] in);
        logic [1:0] n;
        n = s;
        case (s)
            2'd0: if (in == 2'b11) n = 2'd1; else if (in == 2'b10) n = 2'd3;
            2'd1: if (in == 2'b11) n = 2'd2; else if (in == 2'b01) n = 2'd3;
            2'd2: if (in == 2'b10) n = 2'd0; else if (in == 2'b00) n = 2'd3;
            default: if (!in[1]) n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] resp_out(input logic [1:0] s);
        logic [2:0] o;
        case (s)
            2'd0:    o = 3'b000;
            2'd1:    o = 3'b100;
            2'd2:    o = 3'b010;
            default: o = 3'b111;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sa <= 2'd0;
        else sa <= resp_nx(sa, {a_i1, a_i2});

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sb <= 2'd0;
        else sb <= resp_nx(sb, {b_i1, b_i2});

    assign {a_o1, a_o2, a_err} = (mode_a == 2) ? 3'b111 :
                                 (mode_a == 1) ? (resp_out(sa) & 3'b011) : resp_out(sa);
    assign {b_o1, b_o2, b_err} = resp_out(sb);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic go_a(input logic [7:0] r, input logic inj);
        a_start  = 1'b1;
        a_rounds = r;
        a_inject = inj;
        tick();
        a_start  = 1'b0;
    endtask

    logic [1:0] seq1 [7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [1:0] seq2 [10] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01,
                              2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] seq3 [3] = '{2'b10, 2'b00, 2'b00};

    initial begin
        rst_n = 1'b0;
        #2;
        check("rst_drv", {a_i1, a_i2}, 2'b00);
        check("rst_flags", {a_busy, a_done, a_fail, a_stuck}, 4'b0000);
        check("rst_rd", a_rd, 8'd0);
        do_reset();

        // Two clean rounds; a start while busy must be ignored
        go_a(8'd2, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_drv_c%0d", c), {a_i1, a_i2}, seq1[c-1]);
            check($sformatf("t1_busy_c%0d", c), {a_busy, a_done}, 2'b10);
            a_start  = (c == 2);
            a_rounds = (c == 2) ? 8'd5 : 8'd2;
            tick();
        end
        a_start = 1'b0;
        check("t1_done", {a_done, a_busy, a_fail, a_stuck}, 4'b1000);
        check("t1_rd", a_rd, 8'd2);
        tick();
        check("t1_done_off", {a_done, a_i1, a_i2}, 3'b000);

        // GAP=2 single round
        do_reset();
        b_start  = 1'b1;
        b_rounds = 8'd1;
        tick();
        b_start  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("t2_drv_c%0d", c), {b_i1, b_i2}, seq2[c-1]);
            tick();
        end
        check("t2_done", {b_done, b_busy, b_fail, b_stuck}, 4'b1000);
        check("t2_rd", b_rd, 8'd1);

        // Injected error round
        do_reset();
        go_a(8'd1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("t3_drv_c%0d", c), {a_i1, a_i2}, seq3[c-1]);
            tick();
        end
        check("t3_done", {a_done, a_busy, a_fail, a_stuck}, 4'b1000);
        check("t3_rd", a_rd, 8'd1);

        // o1 held low: mismatch seen in cycle 2, recovery exits on 000
        do_reset();
        mode_a = 1;
        go_a(8'd2, 1'b0);
        check("t4_c1", {a_i1, a_i2, a_fail}, 3'b110);
        tick();
        check("t4_c2", {a_i1, a_i2, a_fail}, 3'b110);
        tick();
        check("t4_fail", {a_i1, a_i2, a_fail, a_busy}, 4'b0011);
        tick();
        check("t4_c4", {a_i1, a_i2, a_done}, 3'b000);
        tick();
        check("t4_c5", {a_i1, a_i2, a_done}, 3'b000);
        tick();
        check("t4_done", {a_done, a_busy, a_fail, a_stuck}, 4'b1010);
        check("t4_rd", a_rd, 8'd0);

        // Responder stuck at 111: timeout after 8 recovery cycles
        do_reset();
        mode_a = 2;
        go_a(8'd1, 1'b0);
        tick();
        tick();
        for (int c = 3; c <= 10; c++) begin
            check($sformatf("t5_c%0d", c), {a_i1, a_i2, a_done, a_stuck}, 4'b0000);
            tick();
        end
        check("t5_done", {a_done, a_busy, a_fail, a_stuck}, 4'b1011);
        check("t5_drv", {a_i1, a_i2}, 2'b00);

        // rounds=0 right after the stuck run: flags clear, done next cycle
        mode_a = 0;
        tick();
        go_a(8'd0, 1'b0);
        check("t6_done", {a_done, a_busy, a_fail, a_stuck}, 4'b1000);
        check("t6_drv", {a_i1, a_i2}, 2'b00);
        tick();
        check("t6_after", {a_done, a_i1, a_i2}, 3'b000);

        // Asynchronous reset mid-round
        do_reset();
        go_a(8'd2, 1'b0);
        tick();
        check("t7_pre", {a_i1, a_i2, a_busy}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async", {a_i1, a_i2, a_busy, a_done}, 4'b0000);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t7_nodone_%0d", c), {a_done, a_busy, a_i1, a_i2}, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fsm1_stim_driver.md
Name: fsm1_stim_driver

Overview:
- Initiator-side companion for the team's two-input handshake FSM (inputs i1/i2; registered outputs o1/o2/err).
- Drives i1/i2 through complete IDLE→S1→S2→IDLE rounds and checks the registered {o1,o2,err} response one cycle after every drive.
- On any mismatch it steers the responder back to IDLE and reports failure.
- Used as an on-chip self-test and bring-up stimulus source sitting directly on the responder's input pins.

Parameters:
- RW, 8, width of round count and rounds_done.
- GAP, 0, hold cycles inserted after each step (0 = back-to-back steps).
- RECOV_MAX, 8, maximum RECOV cycles before declaring the responder stuck.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; sampled only when busy=0.
- rounds  in  RW  number of rounds; latched on start.
- inject  in  1  latched on start; first round becomes a deliberate error round.
- i1  out  1  responder input i1 (registered).
- i2  out  1  responder input i2 (registered).
- o1  in  1  responder output.
- o2  in  1  responder output.
- err  in  1  responder output.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- fail  out  1  sticky mismatch flag; cleared on the next accepted start.
- stuck  out  1  sticky recovery-timeout flag; cleared on the next accepted start.
- rounds_done  out  RW  rounds completed without mismatch; cleared on start.

Behaviour:
- Reset (asynchronous): i1=i2=0, busy=0, done=0, fail=0, stuck=0, rounds_done=0, state IDLE, expected={0,0,0}.
- Responder contract, using {i1,i2} → {o1,o2,err}:
  - IDLE: 11→S1 (100); 10→ER (111); 0x holds IDLE (000).
  - S1: 11→S2 (010); 01→ER; x0 holds S1 (100).
  - S2: 10→IDLE (000); 00→ER; x1 holds S2 (010).
  - ER: 0x→IDLE (000); 1x holds ER (111).
- Timing: a value driven in cycle k is sampled by the responder at the end of k. The response is compared in cycle k+1 against the expected register loaded together with the drive.
- States:
  - IDLE: drives 00, no compare. An accepted start with rounds=0 pulses done in the next cycle and drives nothing.
  - STEP: step index 0..2 drives 11, 11, 10; expected values are 100, 010, 000.
    - With inject on round 1, the steps are 10 (expect 111) then 00 (expect 000), and the round ends.
    - After each step, GAP hold cycles follow: drive 00 in S1 or IDLE, 01 in S2; expected = current state's outputs.
  - TAIL: one cycle driving 00, compares the final step's response. Then done=1 for one cycle, busy=0, next state IDLE.
- Compare: every cycle after the first drive. On equality at a round's last step, rounds_done increments by 1 (saturating at all-ones).
- Mismatch → fail=1, enter RECOV the next cycle. Remaining rounds are abandoned.
- RECOV drive rule, chosen from the observed response each cycle:
  - 111 → drive 00.
  - 100 → drive 01.
  - 010 → drive 00.
  - 000 → exit: done pulse, busy=0.
  - Any other code → drive 00.
- RECOV timeout: after RECOV_MAX cycles without observing 000, assert stuck=1, pulse done, return to IDLE driving 00.
- start while busy=1 is ignored. The rounds value is used exactly as latched.
- Reset mid-operation forces i1=i2=0 immediately (asynchronously), with no done pulse.

Test Plan:
- rounds=2, GAP=0, inject=0, correct responder model; start in cycle 0 → {i1,i2} = 11,11,10,11,11,10 in cycles 1–6, 00 in cycle 7; done high in cycle 8; fail=0, stuck=0, rounds_done=2.
- rounds=1, GAP=2 → drive 11,00,00, 11,01,01, 10,00,00, then TAIL; no mismatch; done pulse; rounds_done=1.
- rounds=1, inject=1 → drive 10 (response 111), then 00 (response 000); done; fail=0; rounds_done=1.
- Faulty model: o1 held 0 → mismatch in cycle 2; fail=1; RECOV sees 000 and exits; done with rounds_done=0, stuck=0.
- Responder model stuck at 111, RECOV_MAX=8 → RECOV drives 00 for 8 cycles; then stuck=1, fail=1, done pulse.
- rounds=0 → done in the cycle after start, i1/i2 never leave 0. Separately, assert rst mid-round → i1=i2=0 and busy=0 asynchronously, no done pulse.
